// File: rtl/pe_array_driver_if.sv
// Bus bundle between the pixel source, pe_array_driver and the best-match comparator.
// master drives the pixel beats and start; slave is the PE array side.
interface pe_array_driver_if;
  logic         start;
  logic         pix_valid;
  logic [7:0]   refpix;
  logic [127:0] searchpix;
  logic [127:0] peout;
  logic [15:0]  peready;
  logic [3:0]   vectorx;
  logic [3:0]   vectory;
  logic         compstart;
  logic         busy;
  logic         done;

  modport master (
    output start, pix_valid, refpix, searchpix,
    input  peout, peready, vectorx, vectory, compstart, busy, done
  );

  modport slave (
    input  start, pix_valid, refpix, searchpix,
    output peout, peready, vectorx, vectory, compstart, busy, done
  );
endinterface

// File: rtl/pe_array_driver.sv
// 16-PE absolute-difference array sweeping all 256 motion vectors of one 16-pixel block.
// Optional DIST_MEAN_EN: 12-bit accumulators, peout reports the mean (sum[11:4]) instead of a saturated sum.
module pe_array_driver (
  input logic             clock,
  input logic             reset,
  pe_array_driver_if.slave bus
);

`ifdef DIST_MEAN_EN
  localparam int ACC_W = 12;
`else
  localparam int ACC_W = 8;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         beat_q, beat_d;
  logic [3:0]         pass_q, pass_d;
  logic [7:0]         chain_q [15];
  logic [7:0]         chain_d [15];
  logic [ACC_W-1:0]   acc_q [16];
  logic [ACC_W-1:0]   acc_d [16];
  logic [15:0]        peready_q, peready_d;
  logic [3:0]         vectorx_q, vectorx_d;
  logic [3:0]         vectory_q, vectory_d;
  logic               accept;
  logic [7:0]         pe_ref  [16];
  logic [7:0]         pe_diff [16];

`ifdef DIST_MEAN_EN
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [7:0] d);
    return a + {4'd0, d};
  endfunction
`else
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a, input logic [7:0] d);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, d};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
`endif

  assign accept = (state_q == RUN) && bus.pix_valid;

  // PE j sees the reference pixel presented j accepted beats ago; chain_q[k] holds delay k+1.
  always_comb begin
    pe_ref[0] = bus.refpix;
    for (int j = 1; j < 16; j++) pe_ref[j] = chain_q[j-1];
    for (int j = 0; j < 16; j++) begin
      pe_diff[j] = (pe_ref[j] > bus.searchpix[8*j +: 8]) ? (pe_ref[j] - bus.searchpix[8*j +: 8])
                                                         : (bus.searchpix[8*j +: 8] - pe_ref[j]);
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pass_d    = pass_q;
    chain_d   = chain_q;
    peready_d = '0;
    vectorx_d = '0;
    vectory_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          beat_d  = '0;
          pass_d  = '0;
        end
      end
      RUN: begin
        if (bus.pix_valid) begin
          chain_d[0] = bus.refpix;
          for (int k = 1; k < 15; k++) chain_d[k] = chain_q[k-1];
          // Beat b >= 15 closes the window of PE b-15.
          if (beat_q >= 5'd15) begin
            peready_d = 16'd1 << (beat_q - 5'd15);
            vectorx_d = 4'(beat_q - 5'd15);
            vectory_d = pass_q;
          end
          if (beat_q == 5'd30) begin
            beat_d = '0;
            if (pass_q == 4'd15) begin
              state_d = DONE;
              pass_d  = '0;
            end else begin
              pass_d = pass_q + 4'd1;
            end
          end else begin
            beat_d = beat_q + 5'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int j = 0; j < 16; j++) begin
      acc_d[j] = acc_q[j];
      if (accept) begin
        if (beat_q == 5'(j))
          acc_d[j] = ACC_W'(pe_diff[j]);
        else if ((beat_q > 5'(j)) && (beat_q <= 5'(j + 15)))
          acc_d[j] = acc_add(acc_q[j], pe_diff[j]);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      pass_q    <= '0;
      peready_q <= '0;
      vectorx_q <= '0;
      vectory_q <= '0;
      for (int k = 0; k < 15; k++) chain_q[k] <= '0;
      for (int j = 0; j < 16; j++) acc_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pass_q    <= pass_d;
      peready_q <= peready_d;
      vectorx_q <= vectorx_d;
      vectory_q <= vectory_d;
      for (int k = 0; k < 15; k++) chain_q[k] <= chain_d[k];
      for (int j = 0; j < 16; j++) acc_q[j] <= acc_d[j];
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_lane
`ifdef DIST_MEAN_EN
    assign bus.peout[8*g +: 8] = acc_q[g][11:4];
`else
    assign bus.peout[8*g +: 8] = acc_q[g];
`endif
  end

  assign bus.peready   = peready_q;
  assign bus.vectorx   = vectorx_q;
  assign bus.vectory   = vectory_q;
  assign bus.compstart = (state_q != IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_pe_array_driver.sv
// Self-checking bench for pe_array_driver: table of full-search scenarios plus reset-abort sequence.
module tb_pe_array_driver;

  logic clock = 1'b0;
  logic reset;

  pe_array_driver_if bus ();

  pe_array_driver dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // mode 0: constant ref/search pixels; mode 1: patterned pixels checked against exp_dist.
  typedef struct {
    int         mode;
    logic [7:0] refc;
    logic [7:0] srchc;
    bit         toggle;
    bit         pulse;
    logic [7:0] exp_lane;
    int         exp_done;
  } vec_t;

`ifdef DIST_MEAN_EN
  localparam logic [7:0] LANE_48 = 8'd3;
`else
  localparam logic [7:0] LANE_48 = 8'd48;
`endif

  vec_t vecs [6];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [7:0] pref(input int k);
    return 8'(k * 8 + 70);
  endfunction

  function automatic logic [7:0] psrch(input int x, input int y, input int k);
    int off;
    off = ((x + y + k) % 5) * (x + 1);
    return (k % 2 == 0) ? 8'(k * 8 + 70 + off) : 8'(k * 8 + 70 - off);
  endfunction

  function automatic logic [7:0] exp_dist(input int x, input int y);
    int sum;
    int a;
    int b;
    sum = 0;
    for (int k = 0; k < 16; k++) begin
      a = int'(pref(k));
      b = int'(psrch(x, y, k));
      sum += (a > b) ? (a - b) : (b - a);
    end
`ifdef DIST_MEAN_EN
    return 8'(sum >> 4);
`else
    return (sum > 255) ? 8'hFF : 8'(sum);
`endif
  endfunction

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int bb, input int pp);
    logic [127:0] sp;
    if (v.mode == 0) begin
      bus.refpix = v.refc;
      for (int i = 0; i < 16; i++) sp[8*i +: 8] = v.srchc;
    end else begin
      bus.refpix = (bb < 16) ? pref(bb) : 8'($urandom);
      for (int i = 0; i < 16; i++)
        sp[8*i +: 8] = (bb >= i && bb <= i + 15) ? psrch(i, pp, bb - i) : 8'($urandom);
    end
    bus.searchpix = sp;
  endtask

  task automatic run_search(input vec_t v, input bit abort);
    int         bb;
    int         pp;
    int         nstrobe;
    int         done_cycle;
    int         ex;
    int         ey;
    bit         seen_done;
    logic [7:0] expl;
    bus.start     = 1'b1;
    bus.pix_valid = 1'b0;
    @(negedge clock);
    check_output("idle_before_start", {bus.busy, bus.compstart, bus.done}, 3'b000);
    @(posedge clock); #1;
    bus.start  = 1'b0;
    bb         = 0;
    pp         = 0;
    nstrobe    = 0;
    seen_done  = 1'b0;
    done_cycle = -1;
    for (int c = 1; c < 1200 && !seen_done; c++) begin
      bus.pix_valid = v.toggle ? (c % 2 == 0) : 1'b1;
      bus.start     = v.pulse && pp == 5 && bb == 3;
      apply_stimulus(v, bb, pp);
      if (abort && pp == 3 && bb == 20) begin
        #2 reset = 1'b1;
        #1;
        check_output("reset_abort_outputs",
                     {|bus.peout, bus.peready, bus.vectorx, bus.vectory, bus.busy, bus.compstart, bus.done}, '0);
        @(posedge clock); #1;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.pix_valid = 1'b0;
        @(negedge clock);
        check_output("idle_after_abort", {bus.busy, bus.compstart, bus.done, bus.peready}, '0);
        @(posedge clock); #1;
        return;
      end
      @(negedge clock);
      if (c == 1) check_output("busy_rise", {bus.busy, bus.compstart}, 2'b11);
      if (bus.peready != 16'h0 || bus.done) begin
        ex   = nstrobe % 16;
        ey   = nstrobe / 16;
        expl = (v.mode == 0) ? v.exp_lane : exp_dist(ex, ey);
        check_output("strobe",
                     {bus.peready, bus.vectorx, bus.vectory, bus.peout[8*ex +: 8], bus.done},
                     {16'(1 << ex), 4'(ex), 4'(ey), expl, (nstrobe == 255)});
        nstrobe++;
        if (bus.done) begin
          seen_done  = 1'b1;
          done_cycle = c;
        end
      end
      if (bus.pix_valid) begin
        if (bb == 30) begin
          bb = 0;
          pp++;
        end else begin
          bb++;
        end
      end
      @(posedge clock); #1;
    end
    check_output("done_seen", 64'(seen_done), 64'd1);
    check_output("done_cycle", 64'(done_cycle), 64'(v.exp_done));
    check_output("strobe_count", 64'(nstrobe), 64'd256);
    bus.pix_valid = 1'b0;
    bus.start     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_output("idle_after_done",
                   {bus.busy, bus.compstart, bus.done, bus.peready, bus.vectorx, bus.vectory}, '0);
      @(posedge clock); #1;
    end
    check_output("peout_hold", bus.peout[127:120], (v.mode == 0) ? v.exp_lane : exp_dist(15, 15));
  endtask

  initial begin
    vecs[0] = '{0, 8'h40, 8'h40, 1'b0, 1'b0, 8'h00,   497};
    vecs[1] = '{0, 8'h10, 8'h13, 1'b0, 1'b0, LANE_48, 497};
    vecs[2] = '{0, 8'h00, 8'hFF, 1'b0, 1'b0, 8'hFF,   497};
    vecs[3] = '{0, 8'h40, 8'h40, 1'b1, 1'b0, 8'h00,   993};
    vecs[4] = '{1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00,   497};
    vecs[5] = '{1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00,   993};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.refpix    = '0;
    bus.searchpix = '0;
    repeat (2) @(posedge clock);
    #1;
    check_output("reset_state",
                 {|bus.peout, bus.peready, bus.vectorx, bus.vectory, bus.busy, bus.compstart, bus.done}, '0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int s = 0; s < 6; s++) begin
      $display("[TB] scenario %0d", s);
      run_search(vecs[s], 1'b0);
    end

    $display("[TB] reset during pass 3 beat 20, then clean search");
    run_search(vecs[4], 1'b1);
    run_search(vecs[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
